// File: rtl/dh_modexp_sequencer_if.sv
// Signal bundle joining a DH key-exchange requester, the modexp sequencer and a shared modular multiplier.
// slave is the sequencer's view; master is the combined requester + multiplier view.
interface dh_modexp_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] exponent;
    logic [WIDTH-1:0] modulus;
    logic             mul_start;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_mod;
    logic             mul_done;
    logic [WIDTH-1:0] mul_result;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport slave (
        input  start, base, exponent, modulus, mul_done, mul_result,
        output mul_start, mul_a, mul_b, mul_mod, busy, done, result, err
    );

    modport master (
        output start, base, exponent, modulus, mul_done, mul_result,
        input  mul_start, mul_a, mul_b, mul_mod, busy, done, result, err
    );
endinterface

// File: rtl/dh_modexp_sequencer.sv
// Left-to-right square-and-multiply base^exponent mod modulus over a shared multiplier.
// Latency WIDTH*(L+2) + popcount(exponent)*(L+1) + 1 cycles for multiplier latency L.
// No backpressure: start is ignored while busy; DH_SEQ_TIMEOUT_EN bounds each multiplier wait.
module dh_modexp_sequencer #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    dh_modexp_sequencer_if.slave  bus
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE, SQ_REQ, SQ_WAIT, MUL_REQ, MUL_WAIT, NEXT, DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] mod_q;
    logic [WIDTH-1:0] res_q;
    logic [IW-1:0]    idx;
    logic             accept;
    logic             wait_st;
    logic             timeout_hit;
    logic             mul_start_c;
    logic [WIDTH-1:0] mul_a_c;
    logic [WIDTH-1:0] mul_b_c;

    assign accept  = (state == IDLE) && bus.start;
    assign wait_st = (state == SQ_WAIT) || (state == MUL_WAIT);

`ifdef DH_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
    logic          err_q;

    // Counter sits at zero outside the wait states, so it restarts on every wait entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (!wait_st) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign timeout_hit = wait_st && !bus.mul_done && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (bus.start) state_nxt = SQ_REQ;
            SQ_REQ:   state_nxt = SQ_WAIT;
            SQ_WAIT: begin
                if (bus.mul_done)     state_nxt = exp_q[idx] ? MUL_REQ : NEXT;
                else if (timeout_hit) state_nxt = DONE;
            end
            MUL_REQ:  state_nxt = MUL_WAIT;
            MUL_WAIT: begin
                if (bus.mul_done)     state_nxt = NEXT;
                else if (timeout_hit) state_nxt = DONE;
            end
            NEXT:     state_nxt = (idx == '0) ? DONE : SQ_REQ;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mul_start_c = 1'b0;
        mul_a_c     = '0;
        mul_b_c     = '0;
        case (state)
            SQ_REQ: begin
                mul_start_c = 1'b1;
                mul_a_c     = acc;
                mul_b_c     = acc;
            end
            MUL_REQ: begin
                mul_start_c = 1'b1;
                mul_a_c     = acc;
                mul_b_c     = base_q;
            end
            default: ;
        endcase
    end

    assign bus.mul_start = mul_start_c;
    assign bus.mul_a     = mul_a_c;
    assign bus.mul_b     = mul_b_c;
    assign bus.mul_mod   = mod_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.result    = res_q;

    // mul_done only lands in acc from a wait state, so stray pulses elsewhere are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            base_q <= '0;
            exp_q  <= '0;
            mod_q  <= '0;
            res_q  <= '0;
            idx    <= '0;
        end else begin
            if (accept) begin
                base_q <= bus.base;
                exp_q  <= bus.exponent;
                mod_q  <= bus.modulus;
                acc    <= {{(WIDTH-1){1'b0}}, (bus.modulus != WIDTH'(1))};
                idx    <= IW'(WIDTH - 1);
            end
            if (wait_st && bus.mul_done) begin
                acc <= bus.mul_result;
            end
            if ((state == NEXT) && (idx != '0)) begin
                idx <= idx - IW'(1);
            end
            if (state_nxt == DONE) begin
                res_q <= timeout_hit ? '0 : acc;
            end
        end
    end
endmodule

// File: tb/tb_dh_modexp_sequencer.sv
// Directed and random modexp runs against an arithmetic reference, with a variable-latency multiplier model.
// Timeout case is exercised when DH_SEQ_TIMEOUT_EN is defined; otherwise the unbounded wait is checked.
module tb_dh_modexp_sequencer;
    localparam int W   = 16;
    localparam int TO  = 20;
    localparam int LIM = 5000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dh_modexp_sequencer_if #(.WIDTH(W)) bus();
    dh_modexp_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    int         resp_lat  = 2;
    bit         resp_en   = 1'b1;
    bit         resp_echo = 1'b0;
    logic         resp_done = 1'b0;
    logic         spur_done = 1'b0;
    logic [W-1:0] resp_val  = '0;
    logic [W-1:0] spur_val  = '0;
    int         n_mulstart = 0;
    int         n_done     = 0;

    assign bus.mul_done   = resp_done | spur_done;
    assign bus.mul_result = spur_done ? spur_val : resp_val;

    // Multiplier model: answers L cycles after mul_start; optional echo repeats mul_done with junk.
    initial begin : multiplier
        int           cnt;
        bit           pend;
        bit           echo;
        logic [W-1:0] prod;
        cnt = 0; pend = 1'b0; echo = 1'b0; prod = '0;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (echo) begin
                resp_done = 1'b1;
                resp_val  = ~prod;
                echo      = 1'b0;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend      = 1'b0;
                    resp_done = 1'b1;
                    resp_val  = prod;
                    echo      = resp_echo;
                end
            end
            if (bus.mul_start === 1'b1) begin
                n_mulstart++;
                if (resp_en) begin
                    pend = 1'b1;
                    cnt  = resp_lat;
                    prod = W'((64'(bus.mul_a) * 64'(bus.mul_b)) % 64'(bus.mul_mod));
                end
            end
            if (bus.done === 1'b1) n_done++;
        end
    end

    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                                input logic [W-1:0] m);
        longint unsigned r, x, mm;
        logic [W-1:0]    k;
        mm = 64'(m);
        r  = 64'd1 % mm;
        x  = 64'(b) % mm;
        k  = e;
        while (k != '0) begin
            if (k[0]) r = (r * x) % mm;
            x = (x * x) % mm;
            k = k >> 1;
        end
        return W'(r);
    endfunction

    function automatic int ref_cycles(input logic [W-1:0] e, input int lat);
        return W * (lat + 2) + $countones(e) * (lat + 1) + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // cyc counts cycles from the start cycle to the done cycle; poke retries start while busy.
    task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                          input int lat, input bit poke,
                          output int cyc, output logic [W-1:0] res, output logic err_o);
        @(posedge clk); #1;
        resp_lat   = lat;
        n_mulstart = 0;
        n_done     = 0;
        bus.start    = 1'b1;
        bus.base     = b;
        bus.exponent = e;
        bus.modulus  = m;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < LIM) begin
            if (poke && cyc == 5) begin
                bus.start    = 1'b1;
                bus.base     = W'(2);
                bus.exponent = W'(3);
                bus.modulus  = W'(11);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        res   = bus.result;
        err_o = bus.err;
        @(posedge clk); #1;
        if (cyc >= LIM) pulse_reset();
    endtask

    initial begin : stim
        int           cyc;
        logic [W-1:0] res;
        logic         err_o;
        int           seen;
        bit           busy_seen;

        bus.start = 1'b0; bus.base = '0; bus.exponent = '0; bus.modulus = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_done",      32'(bus.done),      32'd0);
        chk("rst_mul_start", 32'(bus.mul_start), 32'd0);
        chk("rst_mul_mod",   32'(bus.mul_mod),   32'd0);
        chk("rst_result",    32'(bus.result),    32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        rst = 1'b1;

        @(posedge clk); #1;
        spur_val = 16'h1234; spur_done = 1'b1;
        @(posedge clk); #1;
        spur_done = 1'b0;
        @(posedge clk); #1;
        chk("idle_spur_busy",   32'(bus.busy),   32'd0);
        chk("idle_spur_result", 32'(bus.result), 32'd0);

        // 3^5 mod 7 with L=2: 71 cycles between start and done cycles, a 72-cycle span inclusive.
        run_op(16'd3, 16'd5, 16'd7, 2, 1'b0, cyc, res, err_o);
        chk("b3e5_result", 32'(res), 32'(ref_modexp(16'd3, 16'd5, 16'd7)));
        chk("b3e5_err",    32'(err_o), 32'd0);
        chk("b3e5_pulses", 32'(n_mulstart), 32'd18);
        chk("b3e5_cycles", 32'(cyc), 32'(ref_cycles(16'd5, 2)));
        chk("b3e5_dones",  32'(n_done), 32'd1);

        resp_echo = 1'b1;
        run_op(16'd3, 16'd5, 16'd7, 2, 1'b0, cyc, res, err_o);
        resp_echo = 1'b0;
        chk("echo_result", 32'(res), 32'd5);
        chk("echo_pulses", 32'(n_mulstart), 32'd18);
        chk("echo_cycles", 32'(cyc), 32'(ref_cycles(16'd5, 2)));

        run_op(16'd5, 16'd0, 16'd23, 3, 1'b0, cyc, res, err_o);
        chk("e0_result", 32'(res), 32'd1);
        chk("e0_pulses", 32'(n_mulstart), 32'(W));
        run_op(16'd5, 16'd0, 16'd1, 1, 1'b0, cyc, res, err_o);
        chk("m1_result", 32'(res), 32'd0);

        run_op(16'd5, 16'd6, 16'd23, 2, 1'b1, cyc, res, err_o);
        chk("busy_start_result", 32'(res), 32'd8);
        chk("busy_start_dones",  32'(n_done), 32'd1);
        chk("busy_start_pulses", 32'(n_mulstart), 32'(W + 2));

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] rb, re, rm;
            int           rl;
            rb = W'($urandom);
            re = W'($urandom);
            rm = W'($urandom_range(65535, 1));
            rl = $urandom_range(4, 1);
            run_op(rb, re, rm, rl, 1'b0, cyc, res, err_o);
            chk($sformatf("rand%0d_result", i), 32'(res), 32'(ref_modexp(rb, re, rm)));
            chk($sformatf("rand%0d_pulses", i), 32'(n_mulstart), 32'(W + $countones(re)));
            chk($sformatf("rand%0d_cycles", i), 32'(cyc), 32'(ref_cycles(re, rl)));
        end

        // Exponent MSB set: the second mul_start is the first multiply, so the next cycle is MUL_WAIT.
        @(posedge clk); #1;
        resp_lat = 3; n_done = 0;
        bus.start = 1'b1; bus.base = 16'd5; bus.exponent = 16'h8001; bus.modulus = 16'd23;
        @(posedge clk); #1;
        bus.start = 1'b0;
        seen = 0;
        for (int c = 0; c < 200 && seen < 2; c++) begin
            if (bus.mul_start === 1'b1) seen++;
            if (seen < 2) begin
                @(posedge clk); #1;
            end
        end
        chk("rst_mid_reached_mul", 32'(seen), 32'd2);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_busy",    32'(bus.busy),    32'd0);
        chk("rst_mid_mul_mod", 32'(bus.mul_mod), 32'd0);
        chk("rst_mid_result",  32'(bus.result),  32'd0);
        chk("rst_mid_mul_a",   32'(bus.mul_a),   32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        busy_seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.busy !== 1'b0 || bus.mul_start !== 1'b0) busy_seen = 1'b1;
        end
        chk("rst_late_done_idle", 32'(busy_seen), 32'd0);
        chk("rst_late_done_dones", 32'(n_done), 32'd0);
        chk("rst_late_result",    32'(bus.result), 32'd0);

        resp_en = 1'b0;
`ifdef DH_SEQ_TIMEOUT_EN
        run_op(16'd3, 16'd5, 16'd7, 2, 1'b0, cyc, res, err_o);
        chk("timeout_cycles_from_mul_start", 32'(cyc - 1), 32'(TO + 1));
        chk("timeout_err",    32'(err_o), 32'd1);
        chk("timeout_result", 32'(res),   32'd0);
        chk("timeout_dones",  32'(n_done), 32'd1);
`else
        @(posedge clk); #1;
        n_done = 0;
        bus.start = 1'b1; bus.base = 16'd3; bus.exponent = 16'd5; bus.modulus = 16'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3 * TO) @(posedge clk);
        #1;
        chk("nowait_limit_busy", 32'(bus.busy), 32'd1);
        chk("nowait_limit_err",  32'(bus.err),  32'd0);
        chk("nowait_limit_dones", 32'(n_done),  32'd0);
        pulse_reset();
`endif
        resp_en = 1'b1;

        run_op(16'd3, 16'd5, 16'd7, 1, 1'b0, cyc, res, err_o);
        chk("final_result", 32'(res), 32'd5);
        chk("final_err",    32'(err_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
